// File: rtl/capture_playback.sv
// capture_playback: triggered sample capture into RAM, then in-order drain over valid/ready
module capture_playback #(
   parameter int A_WIDTH = 9,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               trigger,
   input  logic               abort,
   input  logic [A_WIDTH-1:0] capture_len,
   input  logic               sample_en,
   input  logic [D_WIDTH-1:0] mic_signal,
   output logic [D_WIDTH-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic               done
);
   typedef enum logic [1:0] {IDLE, CAPTURE, PLAYBACK} state_t;
   state_t state_q, state_d;
   logic [A_WIDTH:0] len_q, len_d, wcnt_q, wcnt_d, iss_q, iss_d, xcnt_q, xcnt_d;
   logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic ov_q, ov_d, sv_q, sv_d, rp_q, rp_d, done_q, done_d;
   logic [D_WIDTH-1:0] od_q, od_d, sd_q, sd_d, rdata_q;
   logic [D_WIDTH-1:0] mem [2**A_WIDTH];
   logic wr_en, rd_en, xfer;
   logic [1:0] occ;

   assign xfer = ov_q & out_ready;
   // words held or in flight once this cycle's transfer leaves; a read is issued only if it will find a slot
   assign occ = 2'(ov_q) + 2'(sv_q) + 2'(rp_q) - 2'(xfer);
   assign wr_en = (state_q == CAPTURE) && sample_en && !abort;
   assign rd_en = (state_q == PLAYBACK) && !abort && (iss_q != len_q) && (occ < 2'd2);
   assign out_data = od_q;
   assign out_valid = ov_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;

   // next-state, pointer/counter and output-pipeline logic; abort overrides everything
   always_comb begin
      state_d = state_q;
      len_d = len_q;
      wcnt_d = wcnt_q;
      iss_d = iss_q;
      xcnt_d = xcnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ov_d = ov_q;
      sv_d = sv_q;
      rp_d = rp_q;
      od_d = od_q;
      sd_d = sd_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d = CAPTURE;
               len_d = (capture_len == '0) ? {1'b1, {A_WIDTH{1'b0}}} : {1'b0, capture_len};
               wr_ptr_d = '0;
               wcnt_d = '0;
            end
         end
         CAPTURE: begin
            if (sample_en) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               wcnt_d = wcnt_q + 1'b1;
               if (wcnt_q + 1'b1 == len_q) begin
                  state_d = PLAYBACK;
                  rd_ptr_d = '0;
                  iss_d = '0;
                  xcnt_d = '0;
               end
            end
         end
         PLAYBACK: begin
            if (rd_en) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               iss_d = iss_q + 1'b1;
            end
            rp_d = rd_en;
            if (xfer || !ov_q) begin
               ov_d = sv_q | rp_q;
               od_d = sv_q ? sd_q : (rp_q ? rdata_q : od_q);
               sv_d = sv_q & rp_q;
               sd_d = rp_q ? rdata_q : sd_q;
            end else if (rp_q) begin
               sv_d = 1'b1;
               sd_d = rdata_q;
            end
            if (xfer) begin
               xcnt_d = xcnt_q + 1'b1;
               if (xcnt_q + 1'b1 == len_q) begin
                  state_d = IDLE;
                  done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
         ov_d = 1'b0;
         sv_d = 1'b0;
         rp_d = 1'b0;
         done_d = 1'b0;
      end
   end

   // control and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         len_q <= '0;
         wcnt_q <= '0;
         iss_q <= '0;
         xcnt_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ov_q <= 1'b0;
         sv_q <= 1'b0;
         rp_q <= 1'b0;
         od_q <= '0;
         sd_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q <= len_d;
         wcnt_q <= wcnt_d;
         iss_q <= iss_d;
         xcnt_q <= xcnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ov_q <= ov_d;
         sv_q <= sv_d;
         rp_q <= rp_d;
         od_q <= od_d;
         sd_q <= sd_d;
         done_q <= done_d;
      end
   end

   // sample RAM with one write port and one registered read port; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= mic_signal;
      if (rd_en) rdata_q <= mem[rd_ptr_q];
   end
endmodule

// File: tb/tb_capture_playback.sv
// tb_capture_playback: scoreboard bench for capture_playback
module tb_capture_playback;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic trigger = 1'b0, abort = 1'b0, sample_en = 1'b0, out_ready = 1'b0;
   logic [8:0] capture_len = '0;
   logic [7:0] mic_signal = '0;
   logic [7:0] out_data;
   logic out_valid, busy, done;
   logic [7:0] sbq[$];
   int n_chk = 0, n_pass = 0;
   logic exp_done = 1'b0, stall_prev = 1'b0;
   logic [7:0] held = '0;

   capture_playback dut (
      .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .capture_len(capture_len),
      .sample_en(sample_en), .mic_signal(mic_signal), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [8:0] len);
      capture_len = len;
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      chk("busy_cap", busy, 1);
   endtask

   task automatic put(input logic [7:0] v, input bit en);
      sample_en = en;
      mic_signal = v;
      if (en) sbq.push_back(v);
      step();
      sample_en = 1'b0;
   endtask

   task automatic drain(input string tag, input bit use_pat, output int nv);
      bit [7:0] rpat = 8'b1110_1001;
      int k = 0;
      bit got = 0;
      nv = 0;
      for (int n = 0; n < 3000; n++) begin
         if (out_valid) nv++;
         out_ready = (use_pat && out_valid && k < 8) ? rpat[k] : 1'b1;
         if (use_pat && out_valid && k < 8) k++;
         step();
         if (done) begin
            got = 1;
            break;
         end
      end
      chk({tag, "_done"}, got, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_left"}, sbq.size(), 0);
   endtask

   // monitor: transfers are judged at the negedge before the edge that completes them
   always @(negedge clk) begin
      if (!rst) begin
         exp_done = 1'b0;
         stall_prev = 1'b0;
      end else begin
         chk("done", done, exp_done);
         if (stall_prev) begin
            chk("hold_v", out_valid, 1);
            chk("hold_d", out_data, held);
         end
         exp_done = 1'b0;
         if (out_valid && out_ready && !abort) begin
            if (sbq.size() == 0) chk("extra_word", 1, 0);
            else begin
               chk("data", out_data, sbq.pop_front());
               exp_done = (sbq.size() == 0);
            end
         end
         stall_prev = out_valid && !out_ready && !abort;
         held = out_data;
      end
   end

   initial begin
      int nv;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_data", out_data, 0);
      rst = 1'b1;
      step();
      // basic capture and drain, no bubbles
      start(9'd4);
      for (int i = 0; i < 4; i++) put(8'(10 + i), 1);
      drain("basic", 0, nv);
      chk("basic_nobubble", nv, 4);
      // backpressure
      start(9'd6);
      for (int i = 1; i <= 6; i++) put(8'(i), 1);
      drain("bp", 1, nv);
      // full depth with wrap
      start(9'd0);
      for (int i = 0; i < 512; i++) begin
         put(8'(i), 1);
         if (i == 255) chk("full_mid_busy", busy, 1);
      end
      drain("full", 0, nv);
      chk("full_nobubble", nv, 512);
      // gapped samples, trigger ignored during capture
      start(9'd3);
      put(8'd5, 1);
      trigger = 1'b1;
      put(8'd99, 0);
      trigger = 1'b0;
      put(8'd6, 1);
      put(8'd99, 0);
      put(8'd7, 1);
      drain("gap", 0, nv);
      // abort after two words played
      start(9'd4);
      for (int i = 0; i < 4; i++) put(8'(20 + i), 1);
      out_ready = 1'b1;
      for (int n = 0; n < 20 && sbq.size() > 2; n++) step();
      chk("abort_reach", sbq.size(), 2);
      abort = 1'b1;
      trigger = 1'b1;
      sbq.delete();
      step();
      abort = 1'b0;
      trigger = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      step();
      chk("abort_idle", busy, 0);
      start(9'd2);
      put(8'd40, 1);
      put(8'd41, 1);
      drain("replay", 0, nv);
      // asynchronous reset mid-playback
      start(9'd4);
      for (int i = 0; i < 4; i++) put(8'(60 + i), 1);
      out_ready = 1'b0;
      for (int n = 0; n < 5 && !out_valid; n++) step();
      chk("pre_rst_valid", out_valid, 1);
      #1 rst = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_data", out_data, 0);
      sbq.delete();
      step();
      step();
      rst = 1'b1;
      out_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         step();
         chk("post_rst_valid", out_valid, 0);
      end
      chk("post_rst_busy", busy, 0);
      start(9'd2);
      put(8'd77, 1);
      put(8'd78, 1);
      drain("post_rst", 0, nv);
      step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/capture_playback.md
Name: capture_playback

Overview:
Triggered capture buffer for the microphone/signal path. On a trigger it records a programmable number of 8-bit samples into an internal 2^A_WIDTH-deep single-port-per-side RAM. It then streams them back out in capture order over a valid/ready interface to a downstream consumer such as the display/host link. It is the reader-side complement to the delay-line path: it stores a window of samples, then drains it under flow control, rather than replaying continuously at a fixed offset.

Parameters:
A_WIDTH, 9, RAM address width; buffer depth = 2^A_WIDTH words
D_WIDTH, 8, sample width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
trigger  input  1  start capture; sampled only in IDLE
abort  input  1  synchronous abort; return to IDLE
capture_len  input  A_WIDTH  words to capture; 0 means 2^A_WIDTH
sample_en  input  1  sample strobe; mic_signal is stored when high during CAPTURE
mic_signal  input  D_WIDTH  input sample
out_data  output  D_WIDTH  playback sample
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts out_data
busy  output  1  high in CAPTURE or PLAYBACK
done  output  1  one-cycle pulse after the final playback transfer

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - state=IDLE; wr_ptr, rd_ptr and counters = 0.
  - out_valid=0, out_data=0, busy=0, done=0.
  - RAM contents are not cleared.
- States: IDLE, CAPTURE, PLAYBACK. A state register drives busy: busy=1 in CAPTURE or PLAYBACK.
- Length latch: len is an A_WIDTH+1-bit register, loaded on the trigger edge. It takes capture_len, or 2^A_WIDTH when capture_len=0. Changes to capture_len during CAPTURE or PLAYBACK have no effect.
- IDLE -> CAPTURE:
  - Occurs when trigger=1 at a rising clk edge and abort=0.
  - wr_ptr is reset to 0 and the write counter is cleared.
- CAPTURE:
  - Each cycle with sample_en=1: mem[wr_ptr] <= mic_signal, then wr_ptr++ and count++.
  - Cycles with sample_en=0 store nothing.
  - trigger is ignored.
  - On the write that makes count == len, the next state is PLAYBACK and rd_ptr=0.
  - Pointers wrap modulo 2^A_WIDTH. Count arithmetic is A_WIDTH+1 bits wide, so a full-depth capture terminates correctly.
- PLAYBACK:
  - The RAM read is synchronous with 1-cycle latency. The implementation prefetches into an output register plus a 1-entry skid buffer.
  - First out_valid=1 occurs no later than 2 cycles after entering PLAYBACK.
  - A transfer happens when out_valid & out_ready at a rising edge.
  - With out_ready held at 1, exactly one word transfers per cycle, with no bubbles after the first word.
  - While out_valid=1 and out_ready=0, out_data and out_valid must hold stable.
  - Words are emitted in addresses 0..len-1, each exactly once, with no duplicates or drops.
  - The cycle after the final transfer: out_valid=0, done=1 for exactly one cycle, state=IDLE, busy=0.
- done is registered and is 0 in every other cycle.
- abort=1 at a rising edge in any state:
  - Next cycle: IDLE, out_valid=0, busy=0, done=0, skid buffer flushed.
  - abort wins over a simultaneous trigger and over a simultaneous final transfer; no done pulse is produced.
- A new trigger after done or abort restarts capture at address 0.
- Reset asserted mid-operation: immediate IDLE with the reset values above. After release, the block waits for a new trigger.
- out_data is don't-care when out_valid=0, but it is held at its last value (0 after reset).

Test Plan:
- Basic capture and drain:
  - Stimulus: capture_len=4, trigger pulse, sample_en=1, mic_signal 10,11,12,13 on consecutive cycles, out_ready=1.
  - Response: out_data 10,11,12,13 on 4 consecutive valid cycles; done pulses once; busy falls.
- Backpressure:
  - Stimulus: capture_len=6, mic_signal 1..6, out_ready pattern 1,0,0,1,0,1,1,1.
  - Response: out_data stays stable while stalled; sequence 1..6 exactly once; done after word 6.
- Full depth and wrap:
  - Stimulus: capture_len=0, mic_signal=index[7:0] for 512 samples, out_ready=1.
  - Response: 512 words 0..255,0..255; done after the 512th word; capture does not end early.
- Gapped input and ignored trigger:
  - Stimulus: sample_en=1,0,1,0,1 with mic_signal 5,99,6,99,7 and capture_len=3; trigger pulsed during CAPTURE.
  - Response: outputs 5,6,7 only; capture is not restarted.
- Abort:
  - Stimulus: abort after 2 of 4 words have been played; then trigger with capture_len=2 and samples 40,41.
  - Response: out_valid=0 and busy=0 the next cycle; no done pulse; replay gives 40,41.
- Async reset:
  - Stimulus: rst=0 mid-PLAYBACK with clk stopped.
  - Response: out_valid, busy, done and out_data all become 0 immediately. After release, out_valid stays 0 until trigger and capture complete.
